// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (op codes 7-10) accumulating into HI/LO.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_start,
   input  logic [3:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   input  logic        md_flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   pend_q, pend_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic          done_q, done_d;

   logic [63:0] prodS, prodU, divSRes, divURes;
   logic [31:0] magA, magB, divisorS, divisorU, quoMag, remMag;
   logic        divZero;

   assign prodS = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
   assign prodU = {32'b0, md_a} * {32'b0, md_b};

   // Signed divide on magnitudes, then restore signs; the zero divisor is swapped for 1
   // only to keep the dividers defined, its result is overridden below.
   assign divZero  = (md_b == 32'd0);
   assign magA     = md_a[31] ? -md_a : md_a;
   assign magB     = md_b[31] ? -md_b : md_b;
   assign divisorS = divZero ? 32'd1 : magB;
   assign divisorU = divZero ? 32'd1 : md_b;
   assign quoMag   = magA / divisorS;
   assign remMag   = magA % divisorS;
   assign divSRes  = divZero ? {md_a, 32'hFFFF_FFFF}
                   : {(md_a[31] ? -remMag : remMag), ((md_a[31] ^ md_b[31]) ? -quoMag : quoMag)};
   assign divURes  = divZero ? {md_a, 32'hFFFF_FFFF} : {md_a % divisorU, md_a / divisorU};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      if (md_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         pend_d  = '0;
      end else if (state_q == RUN) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            hi_d    = pend_q[63:32];
            lo_d    = pend_q[31:0];
            done_d  = 1'b1;
         end
      end else if (md_start) begin
         case (md_op)
            OP_MULT:  begin pend_d = prodS;   cnt_d = CW'(MULT_CYCLES); state_d = RUN; end
            OP_MULTU: begin pend_d = prodU;   cnt_d = CW'(MULT_CYCLES); state_d = RUN; end
            OP_DIV:   begin pend_d = divSRes; cnt_d = CW'(DIV_CYCLES);  state_d = RUN; end
            OP_DIVU:  begin pend_d = divURes; cnt_d = CW'(DIV_CYCLES);  state_d = RUN; end
            OP_MTHI:  hi_d = md_a;
            OP_MTLO:  lo_d = md_a;
`ifdef MDU_MADD_EN
            OP_MADD:  begin pend_d = {hi_q, lo_q} + prodS; cnt_d = CW'(MULT_CYCLES); state_d = RUN; end
            OP_MADDU: begin pend_d = {hi_q, lo_q} + prodU; cnt_d = CW'(MULT_CYCLES); state_d = RUN; end
            OP_MSUB:  begin pend_d = {hi_q, lo_q} - prodS; cnt_d = CW'(MULT_CYCLES); state_d = RUN; end
            OP_MSUBU: begin pend_d = {hi_q, lo_q} - prodU; cnt_d = CW'(MULT_CYCLES); state_d = RUN; end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = done_q;
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized scoreboard bench for mdu_hilo against an arithmetic reference model.
// Compile with MDU_MADD_EN defined to cover the accumulate ops as well.
module tb_mdu_hilo;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd8;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_start, md_flush;
   logic [3:0]  md_op;
   logic [31:0] md_a, md_b;
   logic        busy, done;
   logic [31:0] hi_out, lo_out;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] expQ[$];
   logic [63:0] monExp;
   logic [31:0] modelHi, modelLo;

   mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op),
      .md_a(md_a), .md_b(md_b), .md_flush(md_flush),
      .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   // What {HI,LO} should hold once the op has fully taken effect.
   function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      acc = {hi, lo};
      refResult = {hi, lo};
      case (op)
         4'd1: refResult = sa * sb;
         4'd2: refResult = ua * ub;
         4'd3: if (b == 32'd0) refResult = {a, 32'hFFFF_FFFF};
               else begin
                  q = sa / sb;
                  r = sa % sb;
                  refResult = {r[31:0], q[31:0]};
               end
         4'd4: if (b == 32'd0) refResult = {a, 32'hFFFF_FFFF};
               else refResult = {a % b, a / b};
         4'd5: refResult = {a, lo};
         4'd6: refResult = {hi, a};
`ifdef MDU_MADD_EN
         4'd7:  refResult = acc + sa * sb;
         4'd8:  refResult = acc + ua * ub;
         4'd9:  refResult = acc - sa * sb;
         4'd10: refResult = acc - ua * ub;
`endif
         default: ;
      endcase
   endfunction

   function automatic bit isLong(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
      return (op >= 4'd1 && op <= 4'd4);
`endif
   endfunction

   function automatic int cyclesFor(input logic [3:0] op);
      return (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Holds the request for one sampling edge; returns 1 time unit after that edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, b);
      md_start = 1'b1;
      md_op    = op;
      md_a     = a;
      md_b     = b;
      @(posedge clk);
      #1;
      md_start = 1'b0;
      md_op    = 4'd0;
      md_a     = $urandom;
      md_b     = $urandom;
   endtask

   task automatic issueAndCheck(input logic [3:0] op, input logic [31:0] a, b);
      logic [63:0] exp;
      logic [31:0] oldHi, oldLo;
      int          n;
      exp   = refResult(op, a, b, modelHi, modelLo);
      oldHi = modelHi;
      oldLo = modelLo;
      if (isLong(op)) expQ.push_back(exp);
      applyStimulus(op, a, b);
      if (isLong(op)) begin
         n = 0;
         while (busy === 1'b1 && n < 100) begin
            checkOutput("holdWhileBusy", {hi_out, lo_out}, {oldHi, oldLo});
            n++;
            @(posedge clk);
            #1;
         end
         checkOutput("busyCycles", 64'(n), 64'(cyclesFor(op)));
      end else begin
         checkOutput("noBusy", {63'b0, busy}, 64'd0);
         checkOutput("immediateHiLo", {hi_out, lo_out}, exp);
      end
      modelHi = exp[63:32];
      modelLo = exp[31:0];
   endtask

   // Scoreboard monitor: every done pulse must match the oldest outstanding result.
   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedDone: got done=1 expected none outstanding at %0t", $time);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("commitHiLo", {hi_out, lo_out}, monExp);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          n;

      reset    = 1'b0;
      md_start = 1'b0;
      md_flush = 1'b0;
      md_op    = 4'd0;
      md_a     = 32'd0;
      md_b     = 32'd0;
      modelHi  = 32'd0;
      modelLo  = 32'd0;
      #1;
      checkOutput("resetHiLo", {hi_out, lo_out}, 64'd0);
      checkOutput("resetBusyDone", {62'b0, busy, done}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      issueAndCheck(OP_MULT, 32'hFFFF_FFFF, 32'd2);
      checkOutput("multNeg1x2", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFE);
      issueAndCheck(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
      checkOutput("multuMaxx2", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFE);
      issueAndCheck(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      checkOutput("divNeg7by2", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
      issueAndCheck(OP_DIVU, 32'd7, 32'd0);
      checkOutput("divuBy0", {hi_out, lo_out}, 64'h0000_0007_FFFF_FFFF);
      issueAndCheck(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      checkOutput("divOverflow", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
      issueAndCheck(OP_MTHI, 32'h1234_5678, 32'd0);
      checkOutput("mthi", {hi_out, lo_out}, 64'h1234_5678_8000_0000);

      // mtlo issued while a div is in flight must be dropped.
      expQ.push_back(refResult(OP_DIV, 32'd100, 32'd7, modelHi, modelLo));
      applyStimulus(OP_DIV, 32'd100, 32'd7);
      applyStimulus(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      checkOutput("mtloIgnored", {hi_out, lo_out}, 64'h0000_0002_0000_000E);
      modelHi = 32'd2;
      modelLo = 32'd14;

      // Flush mid-divide: no commit, no done.
      applyStimulus(OP_DIV, 32'd1000, 32'd3);
      repeat (2) begin @(posedge clk); #1; end
      md_flush = 1'b1;
      @(posedge clk);
      #1;
      md_flush = 1'b0;
      checkOutput("flushBusy", {63'b0, busy}, 64'd0);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("flushKeepsHiLo", {hi_out, lo_out}, {modelHi, modelLo});

      // Flush on the commit edge itself wins over the commit.
      applyStimulus(OP_MULTU, 32'd9, 32'd9);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("busyBeforeCommit", {63'b0, busy}, 64'd1);
      md_flush = 1'b1;
      @(posedge clk);
      #1;
      md_flush = 1'b0;
      checkOutput("flushAtCommit", {hi_out, lo_out, 1'b0}, {modelHi, modelLo, busy});

      // Flush beats a simultaneous mthi in IDLE.
      md_flush = 1'b1;
      applyStimulus(OP_MTHI, 32'hAAAA_5555, 32'd0);
      md_flush = 1'b0;
      checkOutput("flushBeatsStart", {hi_out, lo_out}, {modelHi, modelLo});

      issueAndCheck(OP_MTHI, 32'd0, 32'd0);
      issueAndCheck(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
      issueAndCheck(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      checkOutput("madduCarry", {hi_out, lo_out}, 64'h0000_0001_0000_0000);
`else
      checkOutput("madduUndefined", {hi_out, lo_out}, 64'h0000_0000_FFFF_FFFF);
`endif

      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 12));
         a  = pickOperand();
         b  = pickOperand();
         issueAndCheck(op, a, b);
      end

      // Asynchronous reset in the middle of a multiply.
      applyStimulus(OP_MULT, 32'h0001_0000, 32'h0001_0000);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midResetHiLo", {hi_out, lo_out}, 64'd0);
      checkOutput("midResetBusyDone", {62'b0, busy, done}, 64'd0);
      expQ.delete();
      modelHi = 32'd0;
      modelLo = 32'd0;
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      repeat (8) @(posedge clk);
      #1;
      checkOutput("afterResetIdle", {hi_out, lo_out, 1'b0}, {64'd0, busy});

      issueAndCheck(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
